// File: rtl/posture_frame_judge.sv
// posture_frame_judge
//   Frame-level posture judge that sits behind the per-pixel Y/angle threshold
//   stage. It counts flagged pixels per frame, classifies each completed frame
//   as good or bad, and debounces the result into a posture alarm.
//
// Ports
//   clk              pixel clock (single clock domain)
//   rst              synchronous active-high reset
//   y_th_flag        per-pixel Y out-of-range flag
//   angle_th_flag    per-pixel angle flag
//   vs_in            vertical sync, active-high; its rising edge closes a frame
//   de_in            data enable, qualifies the flags
//   y_pix_th         frame is bad if its Y count exceeds this
//   angle_pix_th     frame is bad if its angle count exceeds this
//   y_cnt_frame      Y-flag count of the last completed frame
//   angle_cnt_frame  angle-flag count of the last completed frame
//   frame_valid      one-cycle pulse when the frame counts update
//   frame_bad        classification of the last completed frame
//   alarm            debounced posture alarm
//   alarm_src        bit0 = Y cause, bit1 = angle cause (valid while alarm=1)
//   alarm_events     (only with POSTURE_ALARM_CNT_EN) saturating count of
//                    fresh alarm entries from IDLE/SUSPECT
//
// Optional build macro: POSTURE_ALARM_CNT_EN
//
// Debounce FSM
//   state   | meaning
//   IDLE    | no alarm, no bad frames pending
//   SUSPECT | no alarm yet, counting consecutive bad frames
//   ALARM   | alarm raised, accumulating cause bits
//   RECOVER | alarm still raised, counting consecutive good frames

module posture_frame_judge #(
  parameter int CNT_WID    = 19,
  parameter int ON_FRAMES  = 3,
  parameter int OFF_FRAMES = 5,
  parameter int FRM_WID    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               y_th_flag,
  input  logic               angle_th_flag,
  input  logic               vs_in,
  input  logic               de_in,
  input  logic [CNT_WID-1:0] y_pix_th,
  input  logic [CNT_WID-1:0] angle_pix_th,
  output logic [CNT_WID-1:0] y_cnt_frame,
  output logic [CNT_WID-1:0] angle_cnt_frame,
  output logic               frame_valid,
  output logic               frame_bad,
  output logic               alarm,
  output logic [1:0]         alarm_src
`ifdef POSTURE_ALARM_CNT_EN
  ,
  output logic [15:0]        alarm_events
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    ALARM   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [CNT_WID-1:0] CNT_MAX = '1;
  localparam logic [CNT_WID-1:0] CNT_ONE = CNT_WID'(1);
  localparam logic [FRM_WID-1:0] FRM_ONE = FRM_WID'(1);
  localparam logic [FRM_WID-1:0] ON_CNT  = FRM_WID'(ON_FRAMES);
  localparam logic [FRM_WID-1:0] OFF_CNT = FRM_WID'(OFF_FRAMES);

  state_t             state;
  state_t             st_nxt;
  logic               vs_d;
  logic               sync_armed;
  logic [CNT_WID-1:0] y_acc;
  logic [CNT_WID-1:0] ang_acc;
  logic [CNT_WID-1:0] y_sum;
  logic [CNT_WID-1:0] ang_sum;
  logic [FRM_WID-1:0] frm_cnt;
  logic [FRM_WID-1:0] frm_nxt;
  logic [FRM_WID-1:0] frm_inc;
  logic               frame_end;
  logic [1:0]         cause;
  logic               is_bad;
  logic               alarm_nxt;
  logic [1:0]         src_nxt;

  assign frame_end = vs_in & ~vs_d;

  // Running totals including this cycle's pixel, so a pixel qualified on the
  // vs edge cycle still lands in the closing frame. Saturate, never wrap.
  always_comb begin
    y_sum   = y_acc;
    ang_sum = ang_acc;
    if (de_in && y_th_flag && (y_acc != CNT_MAX))
      y_sum = y_acc + CNT_ONE;
    if (de_in && angle_th_flag && (ang_acc != CNT_MAX))
      ang_sum = ang_acc + CNT_ONE;
  end

  assign cause   = {(ang_sum > angle_pix_th), (y_sum > y_pix_th)};
  assign is_bad  = |cause;
  assign frm_inc = frm_cnt + FRM_ONE;

  always_comb begin
    st_nxt    = state;
    frm_nxt   = frm_cnt;
    alarm_nxt = alarm;
    src_nxt   = alarm_src;
    case (state)
      IDLE: begin
        if (is_bad) begin
          frm_nxt = FRM_ONE;
          if (ON_FRAMES == 1) begin
            st_nxt    = ALARM;
            alarm_nxt = 1'b1;
            src_nxt   = cause;
          end else begin
            st_nxt = SUSPECT;
          end
        end
      end
      SUSPECT: begin
        if (is_bad) begin
          frm_nxt = frm_inc;
          if (frm_inc == ON_CNT) begin
            st_nxt    = ALARM;
            alarm_nxt = 1'b1;
            src_nxt   = cause;
          end
        end else begin
          frm_nxt = '0;
          st_nxt  = IDLE;
        end
      end
      ALARM: begin
        if (is_bad) begin
          src_nxt = alarm_src | cause;
        end else begin
          frm_nxt = FRM_ONE;
          if (OFF_FRAMES == 1) begin
            st_nxt    = IDLE;
            alarm_nxt = 1'b0;
            src_nxt   = 2'b00;
          end else begin
            st_nxt = RECOVER;
          end
        end
      end
      RECOVER: begin
        if (!is_bad) begin
          frm_nxt = frm_inc;
          if (frm_inc == OFF_CNT) begin
            st_nxt    = IDLE;
            alarm_nxt = 1'b0;
            src_nxt   = 2'b00;
          end
        end else begin
          frm_nxt = '0;
          st_nxt  = ALARM;
          src_nxt = alarm_src | cause;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

`ifdef POSTURE_ALARM_CNT_EN
  // Only fresh entries count; falling back from RECOVER is the same episode.
  logic fresh_entry;
  assign fresh_entry = (st_nxt == ALARM) && ((state == IDLE) || (state == SUSPECT));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      vs_d            <= 1'b0;
      sync_armed      <= 1'b0;
      y_acc           <= '0;
      ang_acc         <= '0;
      frm_cnt         <= '0;
      y_cnt_frame     <= '0;
      angle_cnt_frame <= '0;
      frame_valid     <= 1'b0;
      frame_bad       <= 1'b0;
      alarm           <= 1'b0;
      alarm_src       <= 2'b00;
`ifdef POSTURE_ALARM_CNT_EN
      alarm_events    <= '0;
`endif
    end else begin
      vs_d        <= vs_in;
      frame_valid <= 1'b0;
      if (frame_end) begin
        y_acc   <= '0;
        ang_acc <= '0;
        // The first edge after reset closes a partial frame: arm only.
        if (!sync_armed) begin
          sync_armed <= 1'b1;
        end else begin
          y_cnt_frame     <= y_sum;
          angle_cnt_frame <= ang_sum;
          frame_valid     <= 1'b1;
          frame_bad       <= is_bad;
          state           <= st_nxt;
          frm_cnt         <= frm_nxt;
          alarm           <= alarm_nxt;
          alarm_src       <= src_nxt;
`ifdef POSTURE_ALARM_CNT_EN
          if (fresh_entry && (alarm_events != 16'hFFFF))
            alarm_events <= alarm_events + 16'd1;
`endif
        end
      end else begin
        y_acc   <= y_sum;
        ang_acc <= ang_sum;
      end
    end
  end

endmodule

// File: tb/tb_posture_frame_judge.sv
// Directed bench for posture_frame_judge. A second instance with a 4-bit
// counter width shares the pixel stream to exercise counter saturation.

module tb_posture_frame_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        y_th_flag, angle_th_flag, vs_in, de_in;
  logic [18:0] y_pix_th, angle_pix_th;
  logic [18:0] y_cnt_frame, angle_cnt_frame;
  logic        frame_valid, frame_bad, alarm;
  logic [1:0]  alarm_src;
  logic [3:0]  s_th;
  logic [3:0]  s_y_cnt, s_ang_cnt;
  logic        s_frame_valid, s_frame_bad, s_alarm;
  logic [1:0]  s_alarm_src;
`ifdef POSTURE_ALARM_CNT_EN
  logic [15:0] alarm_events, s_alarm_events;
`endif

  posture_frame_judge #(.CNT_WID(19), .ON_FRAMES(3), .OFF_FRAMES(5), .FRM_WID(4)) dut (
    .clk(clk), .rst(rst), .y_th_flag(y_th_flag), .angle_th_flag(angle_th_flag),
    .vs_in(vs_in), .de_in(de_in), .y_pix_th(y_pix_th), .angle_pix_th(angle_pix_th),
    .y_cnt_frame(y_cnt_frame), .angle_cnt_frame(angle_cnt_frame),
    .frame_valid(frame_valid), .frame_bad(frame_bad), .alarm(alarm), .alarm_src(alarm_src)
`ifdef POSTURE_ALARM_CNT_EN
    , .alarm_events(alarm_events)
`endif
  );

  posture_frame_judge #(.CNT_WID(4), .ON_FRAMES(3), .OFF_FRAMES(5), .FRM_WID(4)) u_sat (
    .clk(clk), .rst(rst), .y_th_flag(y_th_flag), .angle_th_flag(angle_th_flag),
    .vs_in(vs_in), .de_in(de_in), .y_pix_th(s_th), .angle_pix_th(s_th),
    .y_cnt_frame(s_y_cnt), .angle_cnt_frame(s_ang_cnt),
    .frame_valid(s_frame_valid), .frame_bad(s_frame_bad), .alarm(s_alarm), .alarm_src(s_alarm_src)
`ifdef POSTURE_ALARM_CNT_EN
    , .alarm_events(s_alarm_events)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    int a;
    bit bad;
  } exp_t;

  exp_t sb[$];
  int   n_tests    = 0;
  int   n_fail     = 0;
  int   fv_pulses  = 0;
  int   exp_pulses = 0;

  always @(negedge clk) if (frame_valid === 1'b1) fv_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; returns after the following posedge, at the
  // negedge, so outputs of that edge are stable for sampling.
  task automatic cyc(input bit v, input bit d, input bit y, input bit a);
    vs_in = v; de_in = d; y_th_flag = y; angle_th_flag = a;
    @(negedge clk);
  endtask

  // One frame: ny Y-flagged and na angle-flagged pixels among at least 10 de
  // cycles, a non-de cycle with flags set (must not count), then the vs edge.
  task automatic frame(input int ny, input int na, input bit edge_y, input bit exp_v,
                       input bit exp_bad, input bit exp_alarm, input logic [1:0] exp_src);
    int   n;
    exp_t e;
    n = (ny > na) ? ny : na;
    if (n < 10) n = 10;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, (i < ny), (i < na));
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    if (exp_v) begin
      e.y = ny + int'(edge_y); e.a = na; e.bad = exp_bad;
      sb.push_back(e);
      exp_pulses++;
    end
    cyc(1'b1, edge_y, edge_y, 1'b0);
    check("frame_valid", 32'(frame_valid), 32'(exp_v));
    if (exp_v) begin
      e = sb.pop_front();
      check("y_cnt_frame", 32'(y_cnt_frame), 32'(e.y));
      check("angle_cnt_frame", 32'(angle_cnt_frame), 32'(e.a));
      check("frame_bad", 32'(frame_bad), 32'(e.bad));
    end
    check("alarm", 32'(alarm), 32'(exp_alarm));
    check("alarm_src", 32'(alarm_src), 32'(exp_src));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("frame_valid_pulse_end", 32'(frame_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_y_cnt"}, 32'(y_cnt_frame), 32'd0);
    check({tag, "_ang_cnt"}, 32'(angle_cnt_frame), 32'd0);
    check({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    check({tag, "_frame_bad"}, 32'(frame_bad), 32'd0);
    check({tag, "_alarm"}, 32'(alarm), 32'd0);
    check({tag, "_alarm_src"}, 32'(alarm_src), 32'd0);
`ifdef POSTURE_ALARM_CNT_EN
    check({tag, "_alarm_events"}, 32'(alarm_events), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    vs_in = 1'b0; de_in = 1'b0; y_th_flag = 1'b0; angle_th_flag = 1'b0;
    y_pix_th = 19'd3; angle_pix_th = 19'd3; s_th = 4'hF;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // First edge only arms; then three Y-bad frames raise the alarm.
    frame(4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    frame(4, 0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    frame(4, 0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    frame(4, 0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01);

    // Angle-only bad frame adds a cause; 4 goods hold; bad returns to ALARM.
    frame(0, 5, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11);
    for (int i = 0; i < 4; i++) frame(1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
    frame(5, 0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11);
    for (int i = 0; i < 4; i++) frame(1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
    frame(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);

    // bad, bad, good, bad never reaches the alarm.
    frame(4, 0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    frame(4, 0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    frame(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    frame(4, 0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);

    // Counts equal to thresholds are good.
    frame(3, 3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    // A pixel qualified on the vs edge cycle belongs to the closing frame.
    frame(3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
    // 20 flagged pixels: the 4-bit instance saturates at 15 (== its threshold).
    frame(20, 0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    check("sat_frame_valid", 32'(s_frame_valid), 32'd0);
    check("sat_y_cnt", 32'(s_y_cnt), 32'd15);
    check("sat_ang_cnt", 32'(s_ang_cnt), 32'd0);
    check("sat_frame_bad", 32'(s_frame_bad), 32'd0);
    // Third consecutive bad frame re-enters ALARM via SUSPECT.
    frame(5, 0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01);
`ifdef POSTURE_ALARM_CNT_EN
    check("alarm_events", 32'(alarm_events), 32'd2);
`endif

    // One-cycle reset mid-frame while in ALARM.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    check_all_zero("midrst");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    frame(4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    frame(2, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);

    repeat (3) @(negedge clk);
    check("frame_valid_pulses", 32'(fv_pulses), 32'(exp_pulses));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("sat_alarm", 32'(s_alarm), 32'd0);
    check("sat_alarm_src", 32'(s_alarm_src), 32'd0);
`ifdef POSTURE_ALARM_CNT_EN
    check("sat_alarm_events", 32'(s_alarm_events), 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
